// File: rtl/norflash_pkg.sv
// Shared definitions for the NOR flash arbiter: command codes, FSM encoding
// and the word-0 packing used on the SPI port.
package norflash_pkg;

    localparam int LINEWIDE = 32;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HI0   = 3'd2,
        ST_LO1   = 3'd3,
        ST_HI1   = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    function automatic logic [31:0] pack_word0(input logic [23:0] addr, input logic [7:0] cmd);
        return {addr, cmd};
    endfunction

endpackage

// File: rtl/norflash_arbiter_rr.sv
// Combinational round-robin picker: searches from last_gnt+1 upward (mod NREQ)
// and reports the first requester found.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_gnt,
    output logic [IDXW-1:0] winner,
    output logic            valid
);

    int idx;

    // Walk from farthest to nearest so the nearest requester after last_gnt wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_gnt) + k) % NREQ;
            if (req[IDXW'(idx)]) begin
                winner = IDXW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/norflash_arbiter.sv
// Round-robin arbiter sharing one SPI NOR flash port between NREQ requesters;
// each grant runs a two-word frame and returns a one-cycle gnt pulse.
module norflash_arbiter #(
    parameter int NREQ     = 2,
    parameter int LINEWIDE = norflash_pkg::LINEWIDE,
    parameter int CLKDIV   = 1
) (
    input  logic                     p_clk,
    input  logic                     p_resetn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*24-1:0]       req_addr,
    input  logic [NREQ*LINEWIDE-1:0] req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [LINEWIDE-1:0]      rdata,
    output logic                     busy,
    output logic [LINEWIDE-1:0]      s_mosi,
    input  logic [LINEWIDE-1:0]      s_miso,
    output logic                     s_clk,
    output logic                     s_css
);
    import norflash_pkg::*;

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW   = $clog2(CLKDIV + 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [IDXW-1:0]     win_q, win_d, last_q, last_d;
    logic                wr_q, wr_d;
    logic [23:0]         addr_q, addr_d;
    logic [LINEWIDE-1:0] wdata_q, wdata_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [LINEWIDE-1:0] rdata_q, rdata_d, mosi_q, mosi_d;
    logic                busy_q, busy_d, sclk_q, sclk_d, css_q, css_d;
    logic [IDXW-1:0]     arb_winner;
    logic                arb_valid;
    logic                phase_done;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
        .req      (req),
        .last_gnt (last_q),
        .winner   (arb_winner),
        .valid    (arb_valid)
    );

    assign phase_done = (phase_q == '0);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mosi_d  = mosi_q;
        unique case (state_q)
            ST_IDLE: if (arb_valid) begin
                state_d = ST_SETUP;
                win_d   = arb_winner;
                wr_d    = req_write[arb_winner];
                addr_d  = req_addr[int'(arb_winner)*24 +: 24];
                wdata_d = req_wdata[int'(arb_winner)*LINEWIDE +: LINEWIDE];
            end
            ST_SETUP: if (phase_done) state_d = ST_HI0;
            ST_HI0:   if (phase_done) state_d = ST_LO1;
            ST_LO1:   if (phase_done) state_d = ST_HI1;
            ST_HI1: if (phase_done) begin
                state_d = ST_HOLD;
                if (!wr_q) rdata_d = s_miso;
            end
            ST_HOLD:  if (phase_done) state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = win_q;
            end
            default:  state_d = ST_IDLE;
        endcase

        if (state_d != state_q)  phase_d = PW'(CLKDIV - 1);
        else if (!phase_done)    phase_d = phase_q - 1'b1;
        else                     phase_d = phase_q;

        // Pin flops are loaded from the next state so they line up with state_q.
        if (state_q == ST_IDLE && state_d == ST_SETUP)
            mosi_d = LINEWIDE'(pack_word0(addr_d, wr_d ? CMD_WRITE : CMD_READ));
        if (state_q == ST_HI0 && state_d == ST_LO1)
            mosi_d = wr_q ? wdata_q : '0;

        css_d  = !(state_d inside {ST_SETUP, ST_HI0, ST_LO1, ST_HI1, ST_HOLD});
        sclk_d = (state_d inside {ST_HI0, ST_HI1});
        busy_d = (state_d != ST_IDLE);
        gnt_d  = '0;
        if (state_d == ST_DONE) gnt_d[win_d] = 1'b1;
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q <= ST_IDLE;
            phase_q <= PW'(CLKDIV - 1);
            win_q   <= '0;
            last_q  <= IDXW'(NREQ - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            rdata_q <= '0;
            mosi_q  <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            css_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            win_q   <= win_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            css_q   <= css_d;
        end
    end

    assign gnt    = gnt_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign s_mosi = mosi_q;
    assign s_clk  = sclk_q;
    assign s_css  = css_q;

endmodule
